// File: rtl/decoder_3to8_strobe_pkg.sv
// Shared definitions for the 3-to-8 strobe decoder and its 8-to-3 encoder twin.
// State encodings, one-hot width and the encoder helper live here.
package decoder_3to8_strobe_pkg;

  localparam int OH_W = 8;
  localparam int CODE_W = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  function automatic logic [CODE_W-1:0] enc_8to3(
    input logic [OH_W-1:0] oh
  );
    logic [CODE_W-1:0] r;
    r = '0;
    for (int b = 0; b < OH_W; b++) begin
      if (oh[b]) r = CODE_W'(b);
    end
    return r;
  endfunction

endpackage

// File: rtl/decoder_3to8_strobe_if.sv
// Code/enable handshake into the strobe decoder.
// The producer drives code and enable; the decoder returns ready.
interface decoder_3to8_strobe_if;
  import decoder_3to8_strobe_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [CODE_W-1:0] i;
  logic              en;

  modport master (
    output in_valid,
    output i,
    output en,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  i,
    input  en,
    output in_ready
  );

endinterface

// File: rtl/decoder_3to8_strobe_dec.sv
// Combinational 3-to-8 one-hot decoder core.
// Exactly one output bit is set for every input code.
module decoder_3to8
  import decoder_3to8_strobe_pkg::*;
(
  input  logic [CODE_W-1:0] i_code,
  output logic [OH_W-1:0]   o_oh
);

  always_comb begin
    o_oh = '0;
    o_oh[i_code] = 1'b1;
  end

endmodule

// File: rtl/decoder_3to8_strobe.sv
// Strobe decoder: a handshaked 3-bit code becomes a one-hot
// line held for PULSE_LEN cycles, then GAP_LEN idle cycles.
module decoder_3to8_strobe
  import decoder_3to8_strobe_pkg::*;
#(
  parameter int PULSE_LEN = 4,
  parameter int GAP_LEN   = 1,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  decoder_3to8_strobe_if.slave bus,
  input  logic                 cnt_clr,
  output logic [OH_W-1:0]      y,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     evt_count
);

  localparam int MAXL =
    (PULSE_LEN > GAP_LEN) ? PULSE_LEN : GAP_LEN;
  localparam int TWC = $clog2(MAXL + 1);
  localparam int TW  = (TWC < 1) ? 1 : TWC;

  localparam logic [TW-1:0] P_LAST =
    TW'(PULSE_LEN - 1);
  localparam logic [TW-1:0] G_LAST =
    (GAP_LEN > 0) ? TW'(GAP_LEN - 1) : '0;

  state_t          r_state;
  state_t          w_nxt_state;
  logic [TW-1:0]   r_cnt;
  logic [TW-1:0]   w_nxt_cnt;
  logic [OH_W-1:0] r_y;
  logic [OH_W-1:0] w_nxt_y;
  logic            r_nop;
  logic            w_nxt_nop;
  logic [CNT_W-1:0] r_evt;
  logic [OH_W-1:0] w_dec;
  logic            w_acc;
  logic            w_strobe;

  decoder_3to8 u_dec (
    .i_code (bus.i),
    .o_oh   (w_dec)
  );

  assign w_acc    = bus.in_valid && (r_state == S_IDLE);
  assign w_strobe = w_acc && bus.en;

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_y     = r_y;
    w_nxt_nop   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_strobe) begin
          w_nxt_state = S_PULSE;
          w_nxt_cnt   = P_LAST;
          w_nxt_y     = w_dec;
        end else if (w_acc) begin
          w_nxt_nop = 1'b1;
        end
      end
      S_PULSE: begin
        if (r_cnt == '0) begin
          w_nxt_y     = '0;
          w_nxt_cnt   = G_LAST;
          w_nxt_state = (GAP_LEN > 0) ? S_GAP : S_IDLE;
        end else begin
          w_nxt_cnt = r_cnt - TW'(1);
        end
      end
      S_GAP: begin
        if (r_cnt == '0) w_nxt_state = S_IDLE;
        else             w_nxt_cnt   = r_cnt - TW'(1);
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_nxt_y     = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_y     <= '0;
      r_nop   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_y     <= w_nxt_y;
      r_nop   <= w_nxt_nop;
    end
  end

  // clear wins over increment, but a same-cycle strobe still counts
  always_ff @(posedge clk) begin
    if (rst) begin
      r_evt <= '0;
    end else if (cnt_clr) begin
      r_evt <= w_strobe ? CNT_W'(1) : '0;
    end else if (w_strobe && (r_evt != '1)) begin
      r_evt <= r_evt + CNT_W'(1);
    end
  end

  assign bus.in_ready = (r_state == S_IDLE);
  assign busy         = (r_state != S_IDLE);
  assign done         = r_nop ||
    ((r_state == S_PULSE) && (r_cnt == '0));
  assign y            = r_y;
  assign evt_count    = r_evt;

endmodule

// File: tb/tb_decoder_3to8_strobe.sv
// Randomized bench for three strobe-decoder configurations
// against a timing-based reference model.
module tb_decoder_3to8_strobe;
  import decoder_3to8_strobe_pkg::*;

  localparam int P0 = 4, G0 = 1, W0 = 8;
  localparam int P1 = 3, G1 = 0, W1 = 8;
  localparam int P2 = 1, G2 = 2, W2 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic t_valid = 1'b0;
  logic t_en = 1'b0;
  logic t_clr = 1'b0;
  logic [2:0] t_i = 3'd0;
  bit chk_on = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  decoder_3to8_strobe_if u_if0 ();
  decoder_3to8_strobe_if u_if1 ();
  decoder_3to8_strobe_if u_if2 ();

  assign u_if0.in_valid = t_valid;
  assign u_if0.i        = t_i;
  assign u_if0.en       = t_en;
  assign u_if1.in_valid = t_valid;
  assign u_if1.i        = t_i;
  assign u_if1.en       = t_en;
  assign u_if2.in_valid = t_valid;
  assign u_if2.i        = t_i;
  assign u_if2.en       = t_en;

  logic [7:0] y0, y1, y2;
  logic busy0, busy1, busy2;
  logic done0, done1, done2;
  logic [W0-1:0] ev0;
  logic [W1-1:0] ev1;
  logic [W2-1:0] ev2;

  decoder_3to8_strobe #(.PULSE_LEN(P0), .GAP_LEN(G0), .CNT_W(W0)) u0 (
    .clk(clk), .rst(rst), .bus(u_if0.slave), .cnt_clr(t_clr),
    .y(y0), .busy(busy0), .done(done0), .evt_count(ev0));
  decoder_3to8_strobe #(.PULSE_LEN(P1), .GAP_LEN(G1), .CNT_W(W1)) u1 (
    .clk(clk), .rst(rst), .bus(u_if1.slave), .cnt_clr(t_clr),
    .y(y1), .busy(busy1), .done(done1), .evt_count(ev1));
  decoder_3to8_strobe #(.PULSE_LEN(P2), .GAP_LEN(G2), .CNT_W(W2)) u2 (
    .clk(clk), .rst(rst), .bus(u_if2.slave), .cnt_clr(t_clr),
    .y(y2), .busy(busy2), .done(done2), .evt_count(ev2));

  // reference model: remember the last accept and derive outputs from timing
  int cyc = 0;
  int t_acc [3];
  bit have [3];
  bit aen [3];
  bit [2:0] acode [3];
  int mcnt [3];

  function automatic int pl(int k);
    return (k == 0) ? P0 : (k == 1) ? P1 : P2;
  endfunction
  function automatic int gl(int k);
    return (k == 0) ? G0 : (k == 1) ? G1 : G2;
  endfunction
  function automatic int mx(int k);
    int w;
    w = (k == 0) ? W0 : (k == 1) ? W1 : W2;
    return (1 << w) - 1;
  endfunction

  function automatic bit m_ready(int k);
    if (!have[k] || !aen[k]) return 1'b1;
    return cyc >= t_acc[k] + pl(k) + gl(k) + 1;
  endfunction
  function automatic logic [7:0] m_y(int k);
    logic [7:0] one;
    one = 8'd1;
    if (have[k] && aen[k] && cyc >= t_acc[k] + 1 &&
        cyc <= t_acc[k] + pl(k))
      return one << acode[k];
    return 8'd0;
  endfunction
  function automatic bit m_done(int k);
    if (!have[k]) return 1'b0;
    if (aen[k]) return cyc == t_acc[k] + pl(k);
    return cyc == t_acc[k] + 1;
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (rst) begin
        have[k] <= 1'b0;
        mcnt[k] <= 0;
      end else begin
        if (t_valid && m_ready(k)) begin
          have[k]  <= 1'b1;
          t_acc[k] <= cyc;
          aen[k]   <= t_en;
          acode[k] <= t_i;
        end
        if (t_clr)
          mcnt[k] <= (t_valid && m_ready(k) && t_en) ? 1 : 0;
        else if (t_valid && m_ready(k) && t_en && mcnt[k] < mx(k))
          mcnt[k] <= mcnt[k] + 1;
      end
    end
    cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic cmp_inst(input int k, input logic [7:0] y,
                          input logic dn, input logic rdy,
                          input logic bz, input logic [31:0] ev);
    string s;
    s = $sformatf("u%0d", k);
    chk({s, ".y"}, 32'(y), 32'(m_y(k)));
    chk({s, ".done"}, 32'(dn), 32'(m_done(k)));
    chk({s, ".in_ready"}, 32'(rdy), 32'(m_ready(k)));
    chk({s, ".busy"}, 32'(bz), 32'(!m_ready(k)));
    chk({s, ".evt_count"}, ev, 32'(mcnt[k]));
    chk({s, ".onehot0"}, 32'($countones(y) <= 1), 32'd1);
    if (y != 8'd0)
      chk({s, ".enc"}, 32'(enc_8to3(y)), 32'(acode[k]));
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      cmp_inst(0, y0, done0, u_if0.in_ready, busy0, 32'(ev0));
      cmp_inst(1, y1, done1, u_if1.in_ready, busy1, 32'(ev1));
      cmp_inst(2, y2, done2, u_if2.in_ready, busy2, 32'(ev2));
    end
  end

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (u_if0.in_ready && u_if1.in_ready && u_if2.in_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("idle_timeout", 32'(ok), 32'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.in_ready", 32'(u_if0.in_ready), 32'd1);
    chk("rst.y", 32'(y0), 32'd0);
    chk("rst.evt", 32'(ev0), 32'd0);
    chk("rst.done", 32'(done0), 32'd0);
    rst = 1'b0;
    chk_on = 1'b1;

    // handshake timing: i=3 then i=5 held until ready returns
    t_valid = 1'b1; t_i = 3'd3; t_en = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk("hs.y", 32'(y0),
          (k <= 4) ? 32'h08 : (k == 7) ? 32'h20 : 32'h00);
      chk("hs.done", 32'(done0), 32'(k == 4));
      chk("hs.ready", 32'(u_if0.in_ready), 32'(k == 6));
      if (k == 1) t_i = 3'd5;
      if (k == 7) t_valid = 1'b0;
    end

    // reset in the second pulse cycle
    wait_idle();
    t_valid = 1'b1; t_i = 3'd2; t_en = 1'b1;
    @(negedge clk);
    chk("rp.y1", 32'(y0), 32'h04);
    t_valid = 1'b0;
    @(negedge clk);
    chk("rp.y2", 32'(y0), 32'h04);
    rst = 1'b1;
    @(negedge clk);
    chk("rp.y", 32'(y0), 32'h00);
    chk("rp.ready", 32'(u_if0.in_ready), 32'd1);
    chk("rp.evt", 32'(ev0), 32'd0);
    chk("rp.done", 32'(done0), 32'd0);
    rst = 1'b0;
    t_valid = 1'b1; t_i = 3'd7;
    @(negedge clk);
    chk("rp.y7", 32'(y0), 32'h80);
    t_valid = 1'b0;

    // en=0 consumes the code with a done pulse only
    wait_idle();
    t_valid = 1'b1; t_i = 3'd6; t_en = 1'b0;
    @(negedge clk);
    chk("nop.y", 32'(y0), 32'h00);
    chk("nop.done", 32'(done0), 32'd1);
    chk("nop.ready", 32'(u_if0.in_ready), 32'd1);
    chk("nop.evt", 32'(ev0), 32'd1);
    t_valid = 1'b0;
    @(negedge clk);
    chk("nop.done2", 32'(done0), 32'd0);

    // clear coincident with a strobe accept
    t_valid = 1'b1; t_i = 3'd1; t_en = 1'b1; t_clr = 1'b1;
    @(negedge clk);
    chk("clr.evt0", 32'(ev0), 32'd1);
    chk("clr.evt2", 32'(ev2), 32'd1);
    t_valid = 1'b0; t_clr = 1'b0;

    // round trip of every code, with jitter on i/en while busy
    for (int c = 0; c < 8; c++) begin
      wait_idle();
      t_valid = 1'b1; t_i = 3'(c); t_en = 1'b1;
      @(negedge clk);
      t_valid = 1'b0;
      for (int n = 0; n < P0; n++) begin
        t_i = 3'($urandom_range(0, 7));
        t_en = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    end
    wait_idle();
    chk("rt.evt0", 32'(ev0), 32'd9);
    chk("sat.evt2", 32'(ev2), 32'd3);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      t_valid = ($urandom_range(0, 99) < 60);
      t_i = 3'($urandom_range(0, 7));
      t_en = ($urandom_range(0, 99) < 80);
      t_clr = ($urandom_range(0, 99) < 3);
      rst = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    rst = 1'b0; t_valid = 1'b0; t_clr = 1'b0;
    repeat (10) @(negedge clk);
    chk_on = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decoder_3to8_strobe.md
Name: decoder_3to8_strobe

Overview:
Sequential counterpart of the team's 8-to-3 encoder. It accepts a 3-bit code over a valid/ready handshake and drives the matching one-hot line on an 8-bit output. The line is held as a strobe for a programmable number of cycles, followed by a programmable idle gap. It sits on the control side, turning encoded select codes back into one-hot enables for downstream blocks.

Parameters:
PULSE_LEN, 4, number of cycles the one-hot strobe is held; legal range >= 1.
GAP_LEN, 1, number of idle cycles after each strobe before the next code is accepted; legal range >= 0.
CNT_W, 8, width of the saturating strobe event counter.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  code and en are valid this cycle.
in_ready  output  1  block can accept a code this cycle.
i  input  3  binary code to decode; ignored when in_valid=0.
en  input  1  1 = generate a strobe; 0 = consume the code with no strobe.
cnt_clr  input  1  synchronous clear of evt_count.
y  output  8  one-hot strobe output; all zeros when idle.
busy  output  1  high in PULSE or GAP.
done  output  1  one-cycle pulse marking the end of a transaction.
evt_count  output  CNT_W  number of strobes issued, saturating.

Behaviour:
- Reset values: y=0, done=0, busy=0, evt_count=0, state=IDLE; in_ready=1 in the first cycle after reset.
- rst has priority over all other inputs. Reset asserted mid-PULSE or mid-GAP clears y on the same edge and returns to IDLE.
- in_ready = (state==IDLE). It is decoded from state only and is never combinationally dependent on in_valid.
- Accept = in_valid && in_ready, sampled at the rising edge; call the accept edge N.
- FSM states: IDLE, PULSE, GAP.
- IDLE, accept with en=1: register y = 8'b1 << i and set the cycle counter to PULSE_LEN-1. Go to PULSE. evt_count += 1, saturating at 2^CNT_W-1.
- IDLE, accept with en=0: y stays 0, state stays IDLE, done=1 for the next cycle only, evt_count is unchanged.
- PULSE: y is held constant and the counter decrements each cycle. The cycle in which counter==0 is the last strobe cycle; done=1 in that cycle. At the next edge y is cleared and the counter is loaded with GAP_LEN-1; go to GAP if GAP_LEN>0, else IDLE.
- GAP: y=0, in_ready=0, counter decrements; at counter==0 go to IDLE.
- Timing summary for an en=1 accept at edge N:
  - y is one-hot in cycles N+1 .. N+PULSE_LEN.
  - done=1 in cycle N+PULSE_LEN.
  - in_ready returns in cycle N+PULSE_LEN+GAP_LEN+1.
  - Minimum accept-to-accept spacing is PULSE_LEN+GAP_LEN+1 cycles.
- y is always one-hot or all zeros, and never has more than one bit set.
- The code is captured at accept. Changes on i or en while busy have no effect.
- cnt_clr: evt_count=0 at the next edge. If cnt_clr and an en=1 accept occur in the same cycle, evt_count=1.
- Saturation: at all-ones, further strobes leave evt_count unchanged.
- Counter width is $clog2(max(PULSE_LEN,GAP_LEN)+1), minimum 1 bit.

Decomposition:
- Shared include: state encodings (IDLE=2'd0, PULSE=2'd1, GAP=2'd2) and the one-hot width constant 8, alongside the existing encoder definitions.
- One natural sub-module: decoder_3to8, a purely combinational core (i -> one-hot). The strobe block instantiates it and registers its output.
- The existing Encoder_8to3 can be used in the bench as a round-trip checker.

Test Plan:
- Round trip: PULSE_LEN=4, GAP_LEN=1; accept i=0..7 with en=1 -> y equals 8'h01, 02, 04 ... 80, each for exactly 4 cycles. Encoder_8to3(y)==i on every strobe cycle. evt_count ends at 8.
- Handshake timing: accept i=3 at edge N -> y=8'h08 in cycles N+1..N+4, done=1 only in N+4, in_ready=0 in N+1..N+5 and 1 in N+6. in_valid held high with i=5 is not accepted before N+6.
- en=0 and GAP_LEN=0: accept i=6, en=0 -> y stays 0, done pulses once, evt_count unchanged, in_ready stays 1. With GAP_LEN=0, an en=1 accept gives in_ready back in the cycle right after the last strobe cycle.
- Reset mid-pulse: accept i=2, assert rst in the 2nd PULSE cycle -> y=0, evt_count=0, done=0, in_ready=1 after that edge. A new accept of i=7 then gives y=8'h80.
- Counter edges: CNT_W=2; 5 strobes -> evt_count saturates at 3. cnt_clr coincident with an en=1 accept -> evt_count=1.
- Input stability: change i and en every cycle while busy -> y is unchanged for the full strobe, with no glitches and no multi-bit values.
